clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parameterised bank of independent clock dividers generating slow square-wave enables and single-cycle tick strobes from the system clock. This is the next generation of the single fixed-ratio toggle divider. It adds:
- multiple channels;
- a run-time programmable half-period;
- glitch-free divisor updates at half-period boundaries;
- per-channel enable;
- a synchronous phase-align of all channels.

It sits next to the board clock and feeds blink, scan and sample-rate logic.

## Interface

Parameters:
- CHANNELS, 4, number of divider channels (1..16)
- CNT_W, 24, width of divisor and counters
- DEFAULT_DIV, 8333333, half-period in clk cycles loaded at reset (≈3 Hz square wave from 50 MHz)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  CHANNELS  per-channel run enable
- sync  in  1  restart all channels in phase
- cfg_we  in  1  divisor write strobe
- cfg_ch  in  clog2(CHANNELS) (min 1)  target channel
- cfg_div  in  CNT_W  new half-period in cycles
- clk_out  out  CHANNELS  divided square waves (registered)
- tick  out  CHANNELS  one-cycle strobe on every clk_out toggle (registered)
- pend  out  CHANNELS  written divisor not yet active

## Operation

- Per-channel state: cnt (CNT_W), act_div (active half-period), nxt_div (pending), pend flag, clk_out, tick.
- Effective divisor d = max(act_div, 1). A value of 0 behaves as 1, so clk_out = clk/2.
- Boundary: en[i]=1 and cnt == d-1. On a boundary edge:
  - cnt <= 0;
  - clk_out[i] toggles;
  - tick[i] <= 1;
  - if pend, act_div <= nxt_div and pend <= 0.
- Non-boundary with en[i]=1: cnt <= cnt+1, tick[i] <= 0.
- en[i]=0: cnt, clk_out and tick hold, except that tick is forced to 0. Any pending divisor is applied immediately (act_div <= nxt_div, pend <= 0).
- Config write (cfg_we=1, cfg_ch < CHANNELS): nxt_div[cfg_ch] <= cfg_div and pend <= 1.
  - Writes with cfg_ch >= CHANNELS are ignored.
  - A second write before the boundary overwrites the first; last write wins.
- Write on the same edge as that channel's boundary: the written value becomes act_div at that edge, and pend stays 0.
- Write to a disabled channel: takes effect on the next edge (act_div updated, pend seen high for at most one cycle).
- sync=1, applied to all channels on one edge:
  - cnt <= 0, clk_out <= 0, tick <= 0;
  - pending divisors are applied and pend cleared;
  - a config write in the same cycle is applied directly as act_div.
- Priority: rst > sync > boundary/count > hold.
- A divisor shrunk below the current cnt never wraps. The compare is cnt >= d-1 and is treated as a boundary. This can only occur via the immediate-apply paths.

## Timing

- Reset values:
  - cnt = 0, act_div = nxt_div = DEFAULT_DIV;
  - pend = 0, clk_out = 0, tick = 0 for all channels.
- After rst or sync deasserts with en high, the first toggle edge is the d-th rising edge. clk_out then has period 2·d cycles and 50% duty.
- tick is high for exactly one cycle, coincident with each clk_out transition (both edges of clk_out).
- Divisor change latency: applies at the next boundary of that channel, so it is glitch-free. No half-period is ever shorter than min(old, new).
- rst or sync mid-half-period abandons the partial count. There is no output glitch other than clk_out being forced to 0.
- Channels are independent. Simultaneous boundaries on several channels are all serviced on the same edge.

## Test plan

- DEFAULT_DIV=5, CHANNELS=2, en=2'b11 after reset -> clk_out[0] rises at cycle 5, falls at cycle 10, period 10; tick high at cycles 5, 10, 15 only.
- Channel 0 running with d=5; write cfg_div=3 at cycle 2 -> pend[0]=1 during cycles 3-5. The half-period ending at cycle 5 is still 5 long, then toggles at cycles 8 and 11.
- Write cfg_div=0 to ch1 on its boundary edge -> pend stays 0; clk_out[1] toggles every cycle thereafter with tick held high.
- en[0] dropped at cycle 7 for 4 cycles -> clk_out[0] and cnt frozen, tick[0]=0. Resuming completes the remaining count; the toggle moves by exactly 4 cycles.
- Channels with d=5 and d=7 drifted out of phase; pulse sync at cycle 20 -> both clk_out=0 at cycle 21, then toggle at cycles 25 and 27 respectively.
- rst asserted mid-count with a pending write -> all outputs 0, pend 0, act_div back to DEFAULT_DIV; cfg_ch=CHANNELS writes produce no change.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent programmable clock dividers producing
// 50% duty square waves and one-cycle toggle strobes from the system clock.
module clk_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 8333333,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CHANNELS-1:0] i_en,
  input  logic                i_sync,
  input  logic                i_cfg_we,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [CNT_W-1:0]    i_cfg_div,
  output logic [CHANNELS-1:0] o_clk_out,
  output logic [CHANNELS-1:0] o_tick,
  output logic [CHANNELS-1:0] o_pend
);

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]    r_cnt     [CHANNELS];
  logic [CNT_W-1:0]    r_act_div [CHANNELS];
  logic [CNT_W-1:0]    r_nxt_div [CHANNELS];
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_clk_out;
  logic [CHANNELS-1:0] r_tick;

  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_bnd;
  logic [CNT_W-1:0]    w_lim [CHANNELS];

  // Write decode and boundary detect; a zero divisor counts as one, and a
  // count already past the limit is treated as a boundary rather than wrapping.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_wr[i] = i_cfg_we && (i_cfg_ch == CH_W'(i));
      if (r_act_div[i] == CNT_ZERO) begin
        w_lim[i] = CNT_ZERO;
      end else begin
        w_lim[i] = r_act_div[i] - CNT_ONE;
      end
      w_bnd[i] = i_en[i] && (r_cnt[i] >= w_lim[i]);
    end
  end

  // Channel state: reset, then phase-align, then boundary/count, then hold.
  // nxt_div equals act_div whenever pend is clear, so applying it unconditionally is safe.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_rst) begin
        r_cnt[i]     <= CNT_ZERO;
        r_act_div[i] <= RST_DIV;
        r_nxt_div[i] <= RST_DIV;
        r_pend[i]    <= 1'b0;
        r_clk_out[i] <= 1'b0;
        r_tick[i]    <= 1'b0;
      end else if (i_sync) begin
        r_cnt[i]     <= CNT_ZERO;
        r_clk_out[i] <= 1'b0;
        r_tick[i]    <= 1'b0;
        r_pend[i]    <= 1'b0;
        if (w_wr[i]) begin
          r_act_div[i] <= i_cfg_div;
          r_nxt_div[i] <= i_cfg_div;
        end else begin
          r_act_div[i] <= r_nxt_div[i];
        end
      end else if (w_bnd[i]) begin
        r_cnt[i]     <= CNT_ZERO;
        r_clk_out[i] <= ~r_clk_out[i];
        r_tick[i]    <= 1'b1;
        r_pend[i]    <= 1'b0;
        if (w_wr[i]) begin
          r_act_div[i] <= i_cfg_div;
          r_nxt_div[i] <= i_cfg_div;
        end else begin
          r_act_div[i] <= r_nxt_div[i];
        end
      end else if (i_en[i]) begin
        r_cnt[i]  <= r_cnt[i] + CNT_ONE;
        r_tick[i] <= 1'b0;
        if (w_wr[i]) begin
          r_nxt_div[i] <= i_cfg_div;
          r_pend[i]    <= 1'b1;
        end else begin
          r_pend[i]    <= r_pend[i];
        end
      end else begin
        // Disabled: outputs freeze, but a pending divisor lands on the next edge.
        r_tick[i] <= 1'b0;
        if (w_wr[i]) begin
          r_nxt_div[i] <= i_cfg_div;
          r_pend[i]    <= 1'b1;
        end else begin
          r_act_div[i] <= r_nxt_div[i];
          r_pend[i]    <= 1'b0;
        end
      end
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_pend    = r_pend;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank (3 channels, default half-period 5).
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] en;
  logic       sync;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [2:0] clk_out;
  logic [2:0] tick;
  logic [2:0] pend;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m0;
  logic [31:0] m1;
  logic [2:0]  ck;
  logic [2:0]  et;
  logic [2:0]  ep;

  clk_div_bank #(
    .CHANNELS   (3),
    .CNT_W      (8),
    .DEFAULT_DIV(5)
  ) u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_sync   (sync),
    .i_cfg_we (cfg_we),
    .i_cfg_ch (cfg_ch),
    .i_cfg_div(cfg_div),
    .o_clk_out(clk_out),
    .o_tick   (tick),
    .o_pend   (pend)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 3'b000; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
    step();
    step();
    chk("rst_clk", clk_out, 3'b000);
    chk("rst_tick", tick, 3'b000);
    chk("rst_pend", pend, 3'b000);

    // Free run at default half-period 5: toggles at 5, 10, 15.
    rst = 1'b0; en = 3'b011;
    ck = 3'b000;
    for (int c = 1; c <= 15; c++) begin
      step();
      et = ((c % 5) == 0) ? 3'b011 : 3'b000;
      ck = ck ^ et;
      chk($sformatf("run_clk c%0d", c), clk_out, ck);
      chk($sformatf("run_tick c%0d", c), tick, et);
    end

    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync1_clk", clk_out, 3'b000);
    chk("sync1_tick", tick, 3'b000);

    // ch0: div 3 written at 2 (lands at 5), en[0] low over edges 13..16.
    // ch1: div 0 written on its boundary at 25, toggles every cycle after.
    m0 = 32'd0; m1 = 32'd0;
    m0[5] = 1'b1; m0[8] = 1'b1; m0[11] = 1'b1; m0[18] = 1'b1;
    m0[21] = 1'b1; m0[24] = 1'b1; m0[27] = 1'b1; m0[30] = 1'b1;
    m1[5] = 1'b1; m1[10] = 1'b1; m1[15] = 1'b1; m1[20] = 1'b1;
    for (int k = 25; k <= 30; k++) m1[k] = 1'b1;
    ck = 3'b000;
    for (int c = 1; c <= 30; c++) begin
      cfg_we = 1'b0;
      if (c == 2) begin cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; end
      if (c == 25) begin cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0; end
      en = (c >= 13 && c <= 16) ? 3'b010 : 3'b011;
      step();
      et = {1'b0, m1[c], m0[c]};
      ck = ck ^ et;
      ep = (c >= 2 && c <= 4) ? 3'b001 : 3'b000;
      chk($sformatf("upd_clk c%0d", c), clk_out, ck);
      chk($sformatf("upd_tick c%0d", c), tick, et);
      chk($sformatf("upd_pend c%0d", c), pend, ep);
    end
    cfg_we = 1'b0; en = 3'b011;

    // Pending div 5 on ch0, then sync together with a direct write of 7 to ch1.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
    step();
    chk("pre_sync_pend", pend, 3'b001);
    sync = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7;
    step();
    sync = 1'b0; cfg_we = 1'b0;
    chk("sync2_clk", clk_out, 3'b000);
    chk("sync2_tick", tick, 3'b000);
    chk("sync2_pend", pend, 3'b000);

    m0 = 32'd0; m1 = 32'd0;
    m0[5] = 1'b1; m0[10] = 1'b1; m0[15] = 1'b1; m0[20] = 1'b1; m0[25] = 1'b1;
    m1[7] = 1'b1; m1[14] = 1'b1; m1[21] = 1'b1;
    ck = 3'b000;
    for (int c = 1; c <= 27; c++) begin
      step();
      et = {1'b0, m1[c], m0[c]};
      ck = ck ^ et;
      chk($sformatf("phase_clk c%0d", c), clk_out, ck);
      chk($sformatf("phase_tick c%0d", c), tick, et);
    end

    // Reset with a divisor still pending must discard it.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
    step();
    chk("pre_rst_pend", pend, 3'b001);
    cfg_we = 1'b0; rst = 1'b1;
    step();
    chk("rst2_clk", clk_out, 3'b000);
    chk("rst2_tick", tick, 3'b000);
    chk("rst2_pend", pend, 3'b000);

    // Write to disabled ch2, then out-of-range writes while ch0/ch1 count.
    rst = 1'b0; en = 3'b011;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd2;
    step();
    chk("dis_wr_pend c1", pend, 3'b100);
    cfg_ch = 2'd3; cfg_div = 8'd1;
    for (int c = 2; c <= 7; c++) begin
      if (c == 6) en = 3'b111;
      step();
      if (c == 2) chk("dis_apply_pend c2", pend, 3'b000);
      if (c == 4) chk("oor_clk c4", clk_out, 3'b000);
      if (c == 5) begin
        chk("oor_clk c5", clk_out, 3'b011);
        chk("oor_tick c5", tick, 3'b011);
        chk("oor_pend c5", pend, 3'b000);
      end
      if (c == 7) begin
        chk("ch2_clk c7", clk_out, 3'b111);
        chk("ch2_tick c7", tick, 3'b100);
        chk("ch2_pend c7", pend, 3'b000);
      end
    end
    cfg_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
